// File: rtl/cart_bram_ext_pkg.sv
// -----------------------------------------------------------------------------
// cart_bram_ext_pkg
// Shared definitions for the byte-enabled block-RAM wrapper:
//   - RDW_OLD / RDW_NEW : same-address read-during-write behaviour selectors
//   - state_t           : wrapper operating state (CLEAR sequence, normal RUN)
//   - read_latency()    : cycles from read strobe to read_valid (1 + OUT_REG)
// -----------------------------------------------------------------------------
package cart_bram_ext_pkg;

    localparam int RDW_OLD = 0;  // collision returns the word before the write
    localparam int RDW_NEW = 1;  // collision returns the byte-merged new word

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int read_latency(input int out_reg);
        return 1 + out_reg;
    endfunction

endpackage

// File: rtl/cart_bram_core.sv
// -----------------------------------------------------------------------------
// cart_bram_core
// Bare simple-dual-port RAM with per-byte write enables and a registered read
// port. Kept free of resets and bypass logic so synthesis maps it to block RAM.
// Ports:
//   clk                     rising-edge clock
//   write_en/addr/data/be   write port; only bytes with be set are updated
//   read_en/addr            read port; read_data loads only when read_en = 1
//   read_data               registered read word (old data on same-address
//                           read-during-write)
// -----------------------------------------------------------------------------
module cart_bram_core
    import cart_bram_ext_pkg::*;
#(
    parameter int A_BITS  = 14,
    parameter int D_BYTES = 1
) (
    input  logic                   clk,
    input  logic                   write_en,
    input  logic [A_BITS-1:0]      write_addr,
    input  logic [8*D_BYTES-1:0]   write_data,
    input  logic [D_BYTES-1:0]     write_be,
    input  logic                   read_en,
    input  logic [A_BITS-1:0]      read_addr,
    output logic [8*D_BYTES-1:0]   read_data
);

    localparam int DW    = 8 * D_BYTES;
    localparam int DEPTH = 1 << A_BITS;

    // NOTE: the array and its read register carry no reset; a reset on RAM
    // storage prevents block-RAM inference, and zeroing is done by the
    // wrapper's clear sequence instead.
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int b = 0; b < D_BYTES; b++) begin
                if (write_be[b]) begin
                    mem[write_addr][8*b +: 8] <= write_data[8*b +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking assignments on both ports mean a same-address read
    // sees the word as it was before this edge's write (read-first RAM).
    always_ff @(posedge clk) begin
        if (read_en) begin
            read_data <= mem[read_addr];
        end
    end

endmodule

// File: rtl/cart_bram_ext.sv
// -----------------------------------------------------------------------------
// cart_bram_ext
// Byte-enabled simple-dual-port RAM wrapper around cart_bram_core adding a
// post-reset clear sequence, optional output register and a configurable
// same-address read-during-write bypass.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   read_addr/strobe  read request; result appears 1+OUT_REG cycles later
//   write_addr/strobe/data/be   byte-enabled write request
//   read_data         read word, holds between reads, 0 after reset
//   read_valid        one-cycle pulse with each new read_data
//   init_busy         high while the array is being zeroed; strobes ignored
// -----------------------------------------------------------------------------
module cart_bram_ext
    import cart_bram_ext_pkg::*;
#(
    parameter int A_BITS         = 14,
    parameter int D_BYTES        = 1,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [A_BITS-1:0]      read_addr,
    input  logic [A_BITS-1:0]      write_addr,
    input  logic                   read_strobe,
    input  logic                   write_strobe,
    input  logic [8*D_BYTES-1:0]   write_data,
    input  logic [D_BYTES-1:0]     write_be,
    output logic [8*D_BYTES-1:0]   read_data,
    output logic                   read_valid,
    output logic                   init_busy
);

    localparam int DW  = 8 * D_BYTES;
    localparam int LAT = read_latency(OUT_REG);

    state_t              state, state_next;
    logic [A_BITS-1:0]   clr_cnt;

    logic                core_we, core_re;
    logic [A_BITS-1:0]   core_waddr;
    logic [DW-1:0]       core_wdata, core_rdata;
    logic [D_BYTES-1:0]  core_wbe;

    // ---------------- state register + clear counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;  // wraps to 0 as CLEAR ends
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_cnt == '1) begin
            state_next = ST_RUN;
        end
    end

    // ---------------- output / port-steering logic ----------------
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        init_busy  = (state == ST_CLEAR);
        core_we    = 1'b0;
        core_re    = 1'b0;
        core_waddr = write_addr;
        core_wdata = write_data;
        core_wbe   = write_be;
        if (!rst) begin
            if (state == ST_CLEAR) begin
                core_we    = 1'b1;
                core_waddr = clr_cnt;
                core_wdata = '0;
                core_wbe   = '1;
            end else begin
                core_we = write_strobe;
                core_re = read_strobe;
            end
        end
    end

    cart_bram_core #(
        .A_BITS  (A_BITS),
        .D_BYTES (D_BYTES)
    ) u_core (
        .clk        (clk),
        .write_en   (core_we),
        .write_addr (core_waddr),
        .write_data (core_wdata),
        .write_be   (core_wbe),
        .read_en    (core_re),
        .read_addr  (read_addr),
        .read_data  (core_rdata)
    );

    // ---------------- collision bypass ----------------
    // Write-side context is captured alongside the RAM read and compared
    // afterwards, keeping the address comparator off the RAM's input path.
    logic [A_BITS-1:0]  raddr_q, waddr_q;
    logic               wr_q;
    logic [DW-1:0]      wdata_q;
    logic [D_BYTES-1:0] wbe_q;
    logic               collide;
    logic [DW-1:0]      merged;

    always_ff @(posedge clk) begin
        if (core_re) begin
            raddr_q <= read_addr;
            waddr_q <= write_addr;
            wr_q    <= write_strobe;
            wdata_q <= write_data;
            wbe_q   <= write_be;
        end
    end

    assign collide = (RDW_MODE == RDW_NEW) && wr_q && (raddr_q == waddr_q);

    always_comb begin
        merged = core_rdata;
        if (collide) begin
            for (int b = 0; b < D_BYTES; b++) begin
                if (wbe_q[b]) begin
                    merged[8*b +: 8] = wdata_q[8*b +: 8];
                end
            end
        end
    end

    // ---------------- output stage ----------------
    if (LAT == 2) begin : g_out_reg
        logic          vld1, vld2;
        logic [DW-1:0] data_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld1   <= 1'b0;
                vld2   <= 1'b0;
                data_q <= '0;
            end else begin
                vld1 <= core_re;
                vld2 <= vld1;
                if (vld1) begin
                    data_q <= merged;
                end
            end
        end

        assign read_valid = vld2;
        assign read_data  = data_q;
    end else begin : g_no_out_reg
        logic vld1, has_data;

        // The core read register has no reset, so the output is forced to
        // zero until the first read after reset has landed in it.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld1     <= 1'b0;
                has_data <= 1'b0;
            end else begin
                vld1 <= core_re;
                if (core_re) begin
                    has_data <= 1'b1;
                end
            end
        end

        assign read_valid = vld1;
        assign read_data  = has_data ? merged : '0;
    end

endmodule

// File: tb/tb_cart_bram_ext.sv
// -----------------------------------------------------------------------------
// tb_cart_bram_ext
// Two instances share one stimulus stream:
//   d0 : OUT_REG=0, RDW_MODE=old  (latency 1)
//   d1 : OUT_REG=1, RDW_MODE=new  (latency 2)
// A word-level model (array + per-instance result queues) predicts read_data,
// read_valid and init_busy every cycle; literal checks pin key values.
// -----------------------------------------------------------------------------
module tb_cart_bram_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  read_addr, write_addr;
    logic        read_strobe, write_strobe;
    logic [15:0] write_data;
    logic [1:0]  write_be;

    logic [15:0] d0_data, d1_data;
    logic        d0_valid, d1_valid, d0_busy, d1_busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    cart_bram_ext #(.A_BITS(4), .D_BYTES(2), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) d0 (
        .clk(clk), .rst(rst), .read_addr(read_addr), .write_addr(write_addr),
        .read_strobe(read_strobe), .write_strobe(write_strobe),
        .write_data(write_data), .write_be(write_be),
        .read_data(d0_data), .read_valid(d0_valid), .init_busy(d0_busy));

    cart_bram_ext #(.A_BITS(4), .D_BYTES(2), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) d1 (
        .clk(clk), .rst(rst), .read_addr(read_addr), .write_addr(write_addr),
        .read_strobe(read_strobe), .write_strobe(write_strobe),
        .write_data(write_data), .write_be(write_be),
        .read_data(d1_data), .read_valid(d1_valid), .init_busy(d1_busy));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    logic [15:0] mem [16];
    rd_t         q0[$], q1[$];
    int          edge_n     = 0;
    int          clear_left = 0;
    bit          started    = 0;
    logic        ev0 = 0, ev1 = 0;
    logic [15:0] ed0 = '0, ed1 = '0;

    function automatic logic [15:0] apply_be(input logic [15:0] old, input logic [15:0] wd,
                                             input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    always @(posedge clk) begin
        logic [15:0] old_w, new_w;
        edge_n++;
        if (rst) begin
            started    = 1;
            clear_left = 16;
            q0.delete();
            q1.delete();
            ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
        end else begin
            if (clear_left > 0) begin
                mem[16 - clear_left] = '0;
                clear_left--;
            end else begin
                if (read_strobe) begin
                    old_w = mem[read_addr];
                    new_w = (write_strobe && write_addr == read_addr)
                            ? apply_be(old_w, write_data, write_be) : old_w;
                    q0.push_back('{edge_n,     old_w});
                    q1.push_back('{edge_n + 1, new_w});
                end
                if (write_strobe) mem[write_addr] = apply_be(mem[write_addr], write_data, write_be);
            end
            ev0 = 0;
            if (q0.size() > 0 && q0[0].due == edge_n) begin
                ev0 = 1; ed0 = q0[0].d; void'(q0.pop_front());
            end
            ev1 = 0;
            if (q1.size() > 0 && q1[0].due == edge_n) begin
                ev1 = 1; ed1 = q1[0].d; void'(q1.pop_front());
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            check("d0_valid", {31'd0, d0_valid}, {31'd0, ev0});
            check("d0_data",  {16'd0, d0_data},  {16'd0, ed0});
            check("d0_busy",  {31'd0, d0_busy},  {31'd0, clear_left > 0});
            check("d1_valid", {31'd0, d1_valid}, {31'd0, ev1});
            check("d1_data",  {16'd0, d1_data},  {16'd0, ed1});
            check("d1_busy",  {31'd0, d1_busy},  {31'd0, clear_left > 0});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic rs, input logic [3:0] ra,
                        input logic ws, input logic [3:0] wa,
                        input logic [15:0] wd, input logic [1:0] be);
        rst = r; read_strobe = rs; read_addr = ra;
        write_strobe = ws; write_addr = wa; write_data = wd; write_be = be;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0, 4'd0, 16'h0, 2'b00);
    endtask

    // Counts cycles with init_busy high on d0, bounded; inputs held as set.
    task automatic count_busy(output int n);
        n = 0;
        while (d0_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nb;

        // reset
        step(1, 0, 4'd0, 0, 4'd0, 16'h0, 2'b00);
        step(1, 0, 4'd0, 0, 4'd0, 16'h0, 2'b00);
        check("rst_d0_data",  {16'd0, d0_data}, 32'h0);
        check("rst_d1_data",  {16'd0, d1_data}, 32'h0);
        check("rst_d0_valid", {31'd0, d0_valid}, 32'h0);
        check("rst_d1_busy",  {31'd0, d1_busy}, 32'h1);

        // clear sequence length
        rst = 0;
        count_busy(nb);
        check("clear_cycles", nb, 32'd16);

        // all 16 addresses read back to back after clear
        for (int i = 0; i < 16; i++) step(0, 1, 4'(i), 0, 4'd0, 16'h0, 2'b00);
        idle(2);
        check("cleared_d1_data", {16'd0, d1_data}, 32'h0);

        // byte-enabled writes and read latency
        step(0, 0, 4'd0, 1, 4'd3, 16'hBEEF, 2'b11);
        step(0, 0, 4'd0, 1, 4'd3, 16'h1234, 2'b01);
        step(0, 1, 4'd3, 0, 4'd0, 16'h0, 2'b00);
        check("lat_d0_valid_c1", {31'd0, d0_valid}, 32'h1);
        check("lat_d1_valid_c1", {31'd0, d1_valid}, 32'h0);
        idle(1);
        check("lat_d0_valid_c2", {31'd0, d0_valid}, 32'h0);
        check("lat_d1_valid_c2", {31'd0, d1_valid}, 32'h1);
        idle(1);
        check("be_d0_data", {16'd0, d0_data}, 32'hBE34);
        check("be_d1_data", {16'd0, d1_data}, 32'hBE34);

        // same-address collision
        step(0, 0, 4'd0, 1, 4'd5, 16'hAAAA, 2'b11);
        step(0, 1, 4'd5, 1, 4'd5, 16'h5555, 2'b10);
        idle(2);
        check("rdw_old_d0", {16'd0, d0_data}, 32'hAAAA);
        check("rdw_new_d1", {16'd0, d1_data}, 32'h55AA);
        step(0, 1, 4'd5, 0, 4'd0, 16'h0, 2'b00);
        idle(2);
        check("after_rdw_d0", {16'd0, d0_data}, 32'h55AA);
        check("after_rdw_d1", {16'd0, d1_data}, 32'h55AA);

        // independent read + write at different addresses, then burst read
        for (int i = 0; i < 8; i++)
            step(0, 1, 4'(i + 8), 1, 4'(i), 16'h1100 + 16'(i), 2'b11);
        for (int i = 0; i < 8; i++) step(0, 1, 4'(i), 0, 4'd0, 16'h0, 2'b00);
        idle(2);
        check("burst_last_d1", {16'd0, d1_data}, 32'h1107);

        // reset during clear, with strobes presented while clearing
        step(1, 0, 4'd0, 0, 4'd0, 16'h0, 2'b00);
        for (int i = 0; i < 7; i++) step(0, 1, 4'd0, 1, 4'd0, 16'hFFFF, 2'b11);
        step(1, 0, 4'd0, 0, 4'd0, 16'h0, 2'b00);
        rst = 0; read_strobe = 1; read_addr = 4'd1;
        write_strobe = 1; write_addr = 4'd0; write_data = 16'hFFFF; write_be = 2'b11;
        count_busy(nb);
        check("reclear_cycles", nb, 32'd16);
        step(0, 1, 4'd0, 0, 4'd0, 16'h0, 2'b00);
        step(0, 1, 4'd3, 0, 4'd0, 16'h0, 2'b00);
        idle(2);
        check("reclear_d0_data", {16'd0, d0_data}, 32'h0);
        check("reclear_d1_data", {16'd0, d1_data}, 32'h0);

        // reset with a read in flight on the two-stage instance
        step(0, 0, 4'd0, 1, 4'd2, 16'h7777, 2'b11);
        step(0, 1, 4'd2, 0, 4'd0, 16'h0, 2'b00);
        check("flight_d0_data", {16'd0, d0_data}, 32'h7777);
        step(1, 0, 4'd0, 0, 4'd0, 16'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'd0, 0, 4'd0, 16'h0, 2'b00);
            check("flight_d1_valid", {31'd0, d1_valid}, 32'h0);
            check("flight_d1_data",  {16'd0, d1_data},  32'h0);
        end
        check("flight_d0_data_rst", {16'd0, d0_data}, 32'h0);
        count_busy(nb);
        check("final_clear_cycles", nb, 32'd13);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
